// File: rtl/pipe_cla_adder.sv
// rtl/pipe_cla_adder.sv - pipelined carry-lookahead adder/subtractor with valid/ready flow control

module pipe_cla_adder #(
    parameter int WIDTH      = 32,
    parameter int STAGE_BLKS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW  = 4 * STAGE_BLKS;
    localparam int LAT = WIDTH / SW;

    // Whole pipe moves together; a stalled output freezes every stage.
    logic adv;

    // 4-bit full lookahead block: returns {c4, s[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic       c1, c2, c3, c4;
        g  = x & y;
        p  = x ^ y;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, p ^ {c3, c2, c1, c0}};
    endfunction

    genvar k;
    generate
        for (k = 0; k < LAT; k++) begin : stg
            // Operand bits still waiting to be summed from this stage upward.
            localparam int WI = WIDTH - k * SW;

            logic                  v_in;
            logic                  c_in;
            logic [WI-1:0]         a_in;
            logic [WI-1:0]         b_in;
            logic [SW-1:0]         slice;
            logic                  c_out;
            logic [(k+1)*SW-1:0]   s_next;
            logic                  v_q;
            logic                  c_q;
            logic [(k+1)*SW-1:0]   s_q;

            if (k == 0) begin : head
                // Subtract is a + ~b + 1; cin only matters for add.
                assign v_in   = in_valid;
                assign c_in   = sub | cin;
                assign a_in   = a;
                assign b_in   = sub ? ~b : b;
                assign s_next = slice;
            end else begin : body
                assign v_in   = stg[k-1].v_q;
                assign c_in   = stg[k-1].c_q;
                assign a_in   = stg[k-1].fwd.a_q;
                assign b_in   = stg[k-1].fwd.b_q;
                assign s_next = {slice, stg[k-1].s_q};
            end

            // Ripple the block carries across this stage's lookahead blocks.
            always_comb begin
                logic       c;
                logic [4:0] r;
                c     = c_in;
                r     = '0;
                slice = '0;
                for (int j = 0; j < STAGE_BLKS; j++) begin
                    r                = cla4(a_in[4*j +: 4], b_in[4*j +: 4], c);
                    slice[4*j +: 4]  = r[3:0];
                    c                = r[4];
                end
                c_out = c;
            end

            // Stage valid, slice carry and the growing deskewed sum.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                end else if (adv) begin
                    v_q <= v_in;
                    c_q <= c_out;
                    s_q <= s_next;
                end
            end

            if (k < LAT - 1) begin : fwd
                logic [WI-SW-1:0] a_q;
                logic [WI-SW-1:0] b_q;
                // Skew the not-yet-summed operand bits to the next stage.
                always_ff @(posedge clk) begin
                    if (adv) begin
                        a_q <= a_in[WI-1:SW];
                        b_q <= b_in[WI-1:SW];
                    end
                end
            end

            if (k == LAT - 1) begin : tail
                logic ovf_q;
                // Carry into the MSB is recovered as s ^ a ^ b at the MSB.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        ovf_q <= 1'b0;
                    end else if (adv) begin
                        ovf_q <= slice[SW-1] ^ a_in[SW-1] ^ b_in[SW-1] ^ c_out;
                    end
                end
            end
        end
    endgenerate

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv && !rst;
    assign out_valid = stg[LAT-1].v_q;
    assign sum       = stg[LAT-1].s_q & {WIDTH{out_valid}};
    assign cout      = stg[LAT-1].c_q & out_valid;
    assign ovf       = stg[LAT-1].tail.ovf_q & out_valid;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// tb/tb_pipe_cla_adder.sv - scoreboard bench for pipe_cla_adder (32-bit and 8-bit instances)

module tb_pipe_cla_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic        cin, sub, cout, ovf;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, sum8;
    logic        cin8, sub8, cout8, ovf8;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pushes = 0;
    int pops = 0;
    int last_pop_cyc = 0;
    logic [33:0] sb_q[$];

    always #5 clk = ~clk;

    pipe_cla_adder #(.WIDTH(32), .STAGE_BLKS(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipe_cla_adder #(.WIDTH(8), .STAGE_BLKS(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    // Reference: {cout, ovf, sum}
    function automatic logic [33:0] ref_model(input logic [31:0] x, input logic [31:0] y,
                                              input logic ci, input logic sb);
        logic [31:0] eb;
        logic [32:0] full;
        logic        v;
        eb   = sb ? ~y : y;
        full = {1'b0, x} + {1'b0, eb} + {32'd0, (sb ? 1'b1 : ci)};
        v    = (x[31] == eb[31]) && (full[31] != x[31]);
        return {full[32], v, full[31:0]};
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard: push on accepted input, pop and compare on completed output.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got sum=%h cout=%b ovf=%b, required no output", sum, cout, ovf);
                end else begin
                    logic [33:0] e;
                    e = sb_q.pop_front();
                    if ({cout, ovf, sum} !== e) begin
                        errors++;
                        $display("FAIL sb_result: got cout=%b ovf=%b sum=%h, required cout=%b ovf=%b sum=%h",
                                 cout, ovf, sum, e[33], e[32], e[31:0]);
                    end
                end
                pops++;
                last_pop_cyc = cyc;
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(ref_model(a, b, cin, sub));
                pushes++;
            end
        end
    end

    task automatic wait_drain();
        int g = 0;
        while (sb_q.size() != 0 && g < 50) begin
            @(negedge clk); #1;
            g++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending, required 0", sb_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, sum, cout, ovf} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b sum=%h cout=%b ovf=%b, required all 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 32'd0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b vld=%b sum=%h, required rdy=1 vld=0 sum=0",
                     in_ready, out_valid, sum);
        end
    endtask

    task automatic test_vec(input string nm, input logic [31:0] va, input logic [31:0] vb,
                            input logic vc, input logic vs, input logic [31:0] es,
                            input logic ec, input logic eo);
        int lat = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; a = va; b = vb; cin = vc; sub = vs; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept: got in_ready=%b, required 1", nm, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        forever begin
            @(negedge clk);
            lat++;
            if (out_valid === 1'b1 || lat >= 20) break;
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL %s_latency: got %0d, required 4", nm, lat);
        end
        checks++;
        if (sum !== es || cout !== ec || ovf !== eo) begin
            errors++;
            $display("FAIL %s_result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                     nm, sum, cout, ovf, es, ec, eo);
        end
        wait_drain();
    endtask

    task automatic test_directed();
        test_vec("add_wrap",   32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        test_vec("add_posovf", 32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        test_vec("add_negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        test_vec("sub_borrow", 32'd5,         32'd7,         1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        test_vec("sub_plain",  32'd7,         32'd5,         1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int p0 = pops;
        int first = 0;
        int g = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = i[0];
            @(negedge clk);
            if (i == 0) first = cyc;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_in_ready[%0d]: got %b, required 1", i, in_ready);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (pops - p0 < 16 && g < 50) begin
            @(negedge clk); #1;
            g++;
        end
        checks++;
        if (pops - p0 != 16) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, required 16", pops - p0);
        end
        checks++;
        if (last_pop_cyc - first != 19) begin
            errors++;
            $display("FAIL b2b_throughput: got span %0d cycles, required 19", last_pop_cyc - first);
        end
    endtask

    task automatic test_stall();
        int p0 = pops;
        int q0 = pushes;
        int n = 0;
        int c = 0;
        logic [31:0] held = '0;
        logic need_new = 1'b1;
        while (n < 10 && c < 100) begin
            @(posedge clk); #1;
            out_ready = !(c >= 5 && c <= 7);
            in_valid  = 1'b1;
            if (need_new) begin
                a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (c >= 5 && c <= 7) begin
                if (c == 5) held = sum;
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== held) begin
                    errors++;
                    $display("FAIL stall_hold[%0d]: got rdy=%b vld=%b sum=%h, required rdy=0 vld=1 sum=%h",
                             c, in_ready, out_valid, sum, held);
                end
            end
            need_new = in_ready;
            if (in_ready) n++;
            c++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        wait_drain();
        checks++;
        if (pushes - q0 != 10 || pops - p0 != 10) begin
            errors++;
            $display("FAIL stall_count: got in=%0d out=%0d, required 10 and 10", pushes - q0, pops - p0);
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'b0; sub = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_in_ready: got %b, required 0", in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL midrst_release: got in_ready=%b, required 1", in_ready);
                end
            end
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_flush[%0d]: got out_valid=%b, required 0", k, out_valid);
            end
        end
    endtask

    task automatic test_small();
        int lat = 0;
        @(posedge clk); #1;
        in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL w8_accept: got in_ready=%b, required 1", in_ready8);
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        forever begin
            @(negedge clk);
            lat++;
            if (out_valid8 === 1'b1 || lat >= 20) break;
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL w8_latency: got %0d, required 2", lat);
        end
        checks++;
        if (sum8 !== 8'h00 || cout8 !== 1'b1 || ovf8 !== 1'b0) begin
            errors++;
            $display("FAIL w8_result: got sum=%h cout=%b ovf=%b, required sum=00 cout=1 ovf=0",
                     sum8, cout8, ovf8);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_mid_reset();
        test_small();
        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: got %0d pending, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and sum width in bits; it must be a multiple of 4*STAGE_BLKS and at least 8.
REQ-002 The block SHALL have parameter STAGE_BLKS, default 2, giving the number of 4-bit lookahead blocks evaluated per pipeline stage.
REQ-003 The block SHALL derive localparam LAT = WIDTH/(4*STAGE_BLKS), the pipeline depth in cycles.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept operands this cycle.
REQ-009 The block SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-010 The block SHALL have port cin, input, 1 bit: carry-in, used only when sub=0.
REQ-011 The block SHALL have port sub, input, 1 bit: 0 selects add, 1 selects subtract.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-014 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-015 The block SHALL have port cout, output, 1 bit: carry-out of the MSB; for subtract, 1 means no borrow.
REQ-016 The block SHALL have port ovf, output, 1 bit: signed two's-complement overflow.

Function
REQ-017 The block SHALL accept a transfer when in_valid && in_ready are both high at a clock edge; it SHALL complete a transfer when out_valid && out_ready are both high.
REQ-018 The block SHALL compute the effective B as b when sub=0 and ~b when sub=1, and the effective carry-in as cin when sub=0 and 1 when sub=1.
REQ-019 The block SHALL make the result sum = a + effB + effCin mod 2^WIDTH, with cout = bit WIDTH of the full sum.
REQ-020 The block SHALL set ovf = carry into the MSB XOR carry out of the MSB.
REQ-021 Each 4-bit block SHALL use full generate/propagate lookahead (g=a&b, p=a^b, c1..c4 as flat sum-of-products); carries between blocks within a stage pass block to block.
REQ-022 Pipeline stage k (0..LAT-1) SHALL compute bit slice [k*4*STAGE_BLKS +: 4*STAGE_BLKS] and register its slice carry-out for stage k+1.
REQ-023 Upper operand slices SHALL be skew-delayed and completed lower sum slices deskew-delayed, so that all bits of one transaction emerge together.
REQ-024 Latency SHALL be exactly LAT cycles from acceptance to out_valid with an unstalled pipe (default LAT=4).
REQ-025 Each stage SHALL carry a valid bit; the pipe advances only when advance = !out_valid || out_ready, and in_ready = advance && !rst.
REQ-026 When advance=0, all stage registers and outputs (sum, cout, ovf, out_valid) SHALL hold stable.
REQ-027 Bubbles (accepted cycles with in_valid=0) SHALL propagate as invalid stages and are not compressed.
REQ-028 Sustained throughput SHALL be one result per cycle when in_valid and out_ready are held high.
REQ-029 Results SHALL emerge in acceptance order; no transaction is lost or duplicated under any pattern of in_valid and out_ready.
REQ-030 The sub, cin and operand values of each transaction SHALL travel with it; mixed add/sub streams are allowed on consecutive cycles.

Reset
REQ-031 While rst is high, all stage valid bits, out_valid, sum, cout and ovf SHALL be 0 at the next edge, and in_ready SHALL be 0.
REQ-032 A reset asserted mid-stream SHALL discard all in-flight transactions; none emerge after reset.
REQ-033 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-034 Operand and deskew data registers do not need a reset, but outputs SHALL read 0 whenever out_valid=0 after reset, until the first result.

Verification (WIDTH=32, STAGE_BLKS=2 unless stated)
REQ-035 The bench SHALL drive a=0xFFFFFFFF, b=1, cin=0, sub=0 and check sum=0x00000000, cout=1, ovf=0, with out_valid 4 cycles after acceptance.
REQ-036 The bench SHALL drive a=0x7FFFFFFF, b=1, sub=0 and check sum=0x80000000, cout=0, ovf=1; a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
REQ-037 The bench SHALL drive sub=1 with a=5, b=7 (cin=1 ignored) and check sum=0xFFFFFFFE, cout=0, ovf=0; a=7, b=5 -> sum=2, cout=1.
REQ-038 The bench SHALL stream 16 random back-to-back transactions with out_ready=1 and check one result per cycle, in order, matching the reference model, including add/sub alternation.
REQ-039 The bench SHALL fill the pipe, drop out_ready for 3 cycles, and check in_ready=0, sum/out_valid stable, then no loss or duplication after resume.
REQ-040 The bench SHALL assert rst for 1 cycle with 3 transactions in flight and check out_valid=0 for the following LAT cycles and in_ready=1 after reset; it SHALL also repeat REQ-035 with WIDTH=8, STAGE_BLKS=1 and check latency 2, sum=0x00, cout=1.
